msx_cart_bus_bridge: RTL
========================

// Module: msx_cart_bus_bridge
// PURPOSE
//  Parametrised bridge between the asynchronous MSX cartridge bus (n_ce/n_trd/n_twr/ta/td)
//  and the internal single-cycle req/ack device bus used by VDP-class cores.
//  Synchronises strobes, holds the Z80 in WAIT until the device acks, drives read data/tdir.
//  Replaces the fixed startup-wait counter and tied-off td/tdir logic in the cartridge top level.
// PARAMETERS
//  ADDR_W         2    width of ta / bus_address
//  SYNC_STAGES    2    flip-flop stages on n_ce, n_trd, n_twr (>=2)
//  STARTUP_WAIT   16   cycles twait held high after reset release
//  TIMEOUT_CYCLES 255  max cycles from bus_req to bus_ack (MSXBUS_TIMEOUT_EN only), <=255
// PORTS
//  clk          in   1       system clock; sole clock
//  reset        in   1       asynchronous, active-high reset
//  n_ce         in   1       cartridge chip enable, active-low, async
//  n_trd        in   1       read strobe, active-low, async
//  n_twr        in   1       write strobe, active-low, async
//  ta           in   ADDR_W  bus address, async; sampled at access start
//  td_in        in   8       bus data in (from td pad)
//  td_out       out  8       bus data out (to td pad)
//  td_oe        out  1       1 = drive td_out onto td
//  tdir         out  1       level-shifter direction, 1 = cartridge->MSX
//  twait        out  1       1 = assert WAIT to MSX
//  bus_req      out  1       device request, held until bus_ack
//  bus_ack      in   1       device acknowledge, 1-cycle pulse
//  bus_wr       out  1       1 = write, 0 = read; valid while bus_req
//  bus_address  out  ADDR_W  latched ta
//  bus_wdata    out  8       latched td_in (writes)
//  bus_rdata    in   8       device read data, valid on bus_ack cycle
//  timeout_flag out  1       sticky: an access timed out
// BEHAVIOUR
//  Reset values: td_out=8'h00, td_oe=0, tdir=0, twait=1, bus_req=0, bus_wr=0,
//   bus_address=0, bus_wdata=0, timeout_flag=0; all sync stages set to 1 (idle).
//  Startup: twait stays 1 for STARTUP_WAIT clk cycles after reset falls; no access accepted
//   before then; then twait=0, FSM enters IDLE.
//  Access detect: sce/srd/swr = synced strobes. start = !sce & (!srd ^ !swr).
//   !srd & !swr together = illegal: no request, FSM stays IDLE until both released.
//  FSM:
//   IDLE  : on start -> REQ. Same edge: twait<=1, bus_address<=ta, bus_wdata<=td_in,
//           bus_wr<=!swr, bus_req<=1 (access-start to bus_req latency = 1 cycle after sync).
//   REQ   : bus_req held; on bus_ack: bus_req<=0; read: td_out<=bus_rdata, td_oe<=1,
//           tdir<=1; twait<=0 (both types) -> HOLD.
//   HOLD  : keep td_out/td_oe/tdir; when sce=1 or (srd=1 & swr=1) -> REL.
//   REL   : td_oe<=0, tdir<=0 (one cycle after strobe release seen) -> IDLE.
//  bus_ack outside REQ is ignored. A new access is accepted only from IDLE, so back-to-back
//   cycles need strobes released between them; a held strobe never re-triggers.
//  Strobe released while in REQ (MSX ignored WAIT): stay in REQ until ack, discard read
//   data, go straight to REL.
//  Reset asserted mid-access: all outputs return to reset values immediately, any
//   outstanding bus_req dropped, STARTUP_WAIT sequence reruns.
// CONFIGURATION
//  MSXBUS_TIMEOUT_EN defined: 8-bit counter runs in REQ; at TIMEOUT_CYCLES without ack:
//   bus_req<=0, read returns td_out=8'hFF, twait<=0, timeout_flag<=1 (cleared only by
//   reset), -> HOLD. An ack arriving after abort is ignored.
//  Not defined: REQ waits indefinitely; counter not built; timeout_flag tied to 0.
// TESTING
//  1 Reset release -> twait=1 exactly 16 cycles, then 0; bus_req stays 0 throughout.
//  2 Write ta=2'b01, td=8'h5A, ack after 3 cycles -> bus_req 1 with bus_wr=1,
//    addr=1, wdata=8'h5A; twait=1 until ack; tdir/td_oe stay 0.
//  3 Read ta=2'b10, bus_rdata=8'hC3 on ack -> td_out=8'hC3, td_oe=tdir=1 until n_trd
//    high, low 1 cycle after synced release; twait low from ack.
//  4 n_trd and n_twr low together -> no bus_req; subsequent normal read serviced.
//  5 (MSXBUS_TIMEOUT_EN) read, no ack -> after 255 cycles td_out=8'hFF, twait=0,
//    timeout_flag=1; late ack ignored.
//  6 reset pulsed while in REQ -> bus_req=0 and td_oe=0 same cycle; startup wait reruns.

Source files
------------

// File: rtl/msx_cart_bus_bridge.sv
// Bridge from the asynchronous MSX cartridge bus to the internal req/ack device bus.
// Define MSXBUS_TIMEOUT_EN to build the REQ-state timeout abort and sticky timeout_flag.
module msx_cart_bus_bridge #(
    parameter int ADDR_W         = 2,
    parameter int SYNC_STAGES    = 2,
    parameter int STARTUP_WAIT   = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              n_ce,
    input  logic              n_trd,
    input  logic              n_twr,
    input  logic [ADDR_W-1:0] ta,
    input  logic [7:0]        td_in,
    output logic [7:0]        td_out,
    output logic              td_oe,
    output logic              tdir,
    output logic              twait,
    output logic              bus_req,
    input  logic              bus_ack,
    output logic              bus_wr,
    output logic [ADDR_W-1:0] bus_address,
    output logic [7:0]        bus_wdata,
    input  logic [7:0]        bus_rdata,
    output logic              timeout_flag
);
    localparam int SW_W = (STARTUP_WAIT > 1) ? $clog2(STARTUP_WAIT) : 1;

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    typedef enum logic [2:0] {
        ST_STARTUP,
        ST_IDLE,
        ST_REQ,
        ST_HOLD,
        ST_REL
    } state_t;

    state_t                 state_q;
    logic [SW_W-1:0]        start_cnt_q;
    logic [SYNC_STAGES-1:0] ce_sync_q, rd_sync_q, wr_sync_q;
    logic [7:0]             td_out_q, bus_wdata_q;
    logic [ADDR_W-1:0]      bus_address_q;
    logic                   td_oe_q, tdir_q, twait_q, bus_req_q, bus_wr_q;
    logic                   block_q, rel_seen_q;
    logic                   sce, srd, swr, start, released;

    // Strobes idle high, so every sync stage resets to 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ce_sync_q <= '1;
            rd_sync_q <= '1;
            wr_sync_q <= '1;
        end else begin
            ce_sync_q <= {ce_sync_q[SYNC_STAGES-2:0], n_ce};
            rd_sync_q <= {rd_sync_q[SYNC_STAGES-2:0], n_trd};
            wr_sync_q <= {wr_sync_q[SYNC_STAGES-2:0], n_twr};
        end
    end

    assign sce      = ce_sync_q[SYNC_STAGES-1];
    assign srd      = rd_sync_q[SYNC_STAGES-1];
    assign swr      = wr_sync_q[SYNC_STAGES-1];
    assign start    = ~sce & (srd ^ swr);
    assign released = sce | (srd & swr);

`ifdef MSXBUS_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] to_cnt_q;
    logic       timeout_q;
    assign timeout_flag = timeout_q;
`else
    assign timeout_flag = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_STARTUP;
            start_cnt_q   <= '0;
            td_out_q      <= 8'h00;
            td_oe_q       <= 1'b0;
            tdir_q        <= 1'b0;
            twait_q       <= 1'b1;
            bus_req_q     <= 1'b0;
            bus_wr_q      <= 1'b0;
            bus_address_q <= '0;
            bus_wdata_q   <= 8'h00;
            block_q       <= 1'b0;
            rel_seen_q    <= 1'b0;
`ifdef MSXBUS_TIMEOUT_EN
            to_cnt_q      <= 8'h00;
            timeout_q     <= 1'b0;
`endif
        end else begin
            // Both strobes low is illegal; stay locked out until both are seen high again.
            if (~srd & ~swr)
                block_q <= 1'b1;
            else if (srd & swr)
                block_q <= 1'b0;

            case (state_q)
                ST_STARTUP: begin
                    if (start_cnt_q == SW_W'(STARTUP_WAIT - 1)) begin
                        twait_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        start_cnt_q <= start_cnt_q + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (start && !block_q) begin
                        twait_q       <= 1'b1;
                        bus_address_q <= ta;
                        bus_wdata_q   <= td_in;
                        bus_wr_q      <= ~swr;
                        bus_req_q     <= 1'b1;
                        rel_seen_q    <= 1'b0;
                        state_q       <= ST_REQ;
`ifdef MSXBUS_TIMEOUT_EN
                        to_cnt_q      <= 8'h00;
`endif
                    end
                end
                ST_REQ: begin
                    // MSX may drop the strobe despite WAIT; remember it so read data is discarded.
                    if (released)
                        rel_seen_q <= 1'b1;
                    if (bus_ack) begin
                        bus_req_q <= 1'b0;
                        twait_q   <= 1'b0;
                        if (released || rel_seen_q) begin
                            state_q <= ST_REL;
                        end else begin
                            if (!bus_wr_q) begin
                                td_out_q <= bus_rdata;
                                td_oe_q  <= 1'b1;
                                tdir_q   <= 1'b1;
                            end
                            state_q <= ST_HOLD;
                        end
                    end
`ifdef MSXBUS_TIMEOUT_EN
                    else if (to_cnt_q == TO_LAST) begin
                        bus_req_q <= 1'b0;
                        twait_q   <= 1'b0;
                        timeout_q <= 1'b1;
                        if (released || rel_seen_q) begin
                            state_q <= ST_REL;
                        end else begin
                            if (!bus_wr_q) begin
                                td_out_q <= 8'hFF;
                                td_oe_q  <= 1'b1;
                                tdir_q   <= 1'b1;
                            end
                            state_q <= ST_HOLD;
                        end
                    end else begin
                        to_cnt_q <= to_cnt_q + 8'd1;
                    end
`endif
                end
                ST_HOLD: begin
                    if (released)
                        state_q <= ST_REL;
                end
                ST_REL: begin
                    td_oe_q <= 1'b0;
                    tdir_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign td_out      = td_out_q;
    assign td_oe       = td_oe_q;
    assign tdir        = tdir_q;
    assign twait       = twait_q;
    assign bus_req     = bus_req_q;
    assign bus_wr      = bus_wr_q;
    assign bus_address = bus_address_q;
    assign bus_wdata   = bus_wdata_q;
endmodule
